// File: rtl/i_fetch_pkg.sv
// Shared types and helpers for the pipelined instruction-fetch router.
//   ILLEGAL_INSTR  : word returned for illegal fetches
//   rsp_t          : response payload {err, data}
//   region_of()    : region index from the top bits of a byte address
//   word_addr_of() : in-region word address (drops region and byte bits)
package i_fetch_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] ILLEGAL_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic            err;
      logic [XLEN-1:0] data;
   } rsp_t;

   function automatic logic [31:0] region_of(input logic [31:0] addr,
                                             input int unsigned addr_len,
                                             input int unsigned region_bits);
      return (addr >> (addr_len - region_bits)) & ((32'd1 << region_bits) - 32'd1);
   endfunction

   function automatic logic [31:0] word_addr_of(input logic [31:0] addr,
                                                input int unsigned addr_len,
                                                input int unsigned region_bits);
      return (addr & ((32'd1 << (addr_len - region_bits)) - 32'd1)) >> 2;
   endfunction

endpackage

// File: rtl/i_fetch_mux_if.sv
// Fetch-router bus: core request/response channels plus the memory read port.
//   master : core and instruction memories (drive requests, read data, rsp_ready)
//   slave  : the router (drives req_ready, responses, memory enables/address)
interface i_fetch_mux_if #(
   parameter int unsigned XLEN        = 32,
   parameter int unsigned ADDR_LEN    = 14,
   parameter int unsigned NUM_REGIONS = 2
);
   localparam int unsigned REGION_BITS = $clog2(NUM_REGIONS);
   localparam int unsigned MEM_AW      = ADDR_LEN - REGION_BITS - 2;

   logic                        flush;
   logic                        req_valid;
   logic                        req_ready;
   logic [ADDR_LEN-1:0]         req_addr;
   logic                        rsp_valid;
   logic                        rsp_ready;
   logic [XLEN-1:0]             rsp_data;
   logic                        rsp_err;
   logic [NUM_REGIONS-1:0]      mem_en;
   logic [MEM_AW-1:0]           mem_addr;
   logic [NUM_REGIONS*XLEN-1:0] mem_rdata;

   modport master (
      output flush, req_valid, req_addr, rsp_ready, mem_rdata,
      input  req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_addr
   );

   modport slave (
      input  flush, req_valid, req_addr, rsp_ready, mem_rdata,
      output req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_addr
   );
endinterface

// File: rtl/i_fetch_rsp_fifo.sv
// Response buffer: synchronous FIFO of rsp_t with a registered head.
//   clk, rstb   : clock, async active-low reset
//   push_i      : write push_data_i at the tail
//   pop_i       : drop the head (only while occ_o != 0)
//   clear_i     : empty the FIFO; overrides push/pop
//   occ_o       : current occupancy
//   head_o      : oldest entry (zero out of reset)
module i_fetch_rsp_fifo #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned OCC_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rstb,
   input  logic               push_i,
   input  i_fetch_pkg::rsp_t  push_data_i,
   input  logic               pop_i,
   input  logic               clear_i,
   output logic [OCC_W-1:0]   occ_o,
   output i_fetch_pkg::rsp_t  head_o
);
   import i_fetch_pkg::*;

   localparam int unsigned PTR_W = $clog2(DEPTH);

   rsp_t             mem_q [DEPTH];
   logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q;
   logic [OCC_W-1:0] occ_q;

   // Pointer wrap that also works for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else if (clear_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
            wr_ptr_q        <= ptr_inc(wr_ptr_q);
         end
         if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
         occ_q <= occ_q + OCC_W'(push_i) - OCC_W'(pop_i);
      end
   end

   assign occ_o  = occ_q;
   assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/i_fetch_mux.sv
// Pipelined instruction-fetch router: decodes each fetch to a region, issues a
// one-cycle synchronous memory read, and returns {data, err} through a buffered
// valid/ready response channel with branch flush.
//   clk, rstb : clock, async active-low reset
//   bus       : slave side of i_fetch_mux_if (request, response, memory port)
module i_fetch_mux #(
   parameter int unsigned            XLEN        = 32,
   parameter int unsigned            ADDR_LEN    = 14,
   parameter int unsigned            NUM_REGIONS = 2,
   parameter logic [NUM_REGIONS-1:0] REGION_EN   = {NUM_REGIONS{1'b1}},
   parameter int unsigned            RSP_DEPTH   = 2
) (
   input logic          clk,
   input logic          rstb,
   i_fetch_mux_if.slave bus
);
   import i_fetch_pkg::*;

   localparam int unsigned REGION_BITS = $clog2(NUM_REGIONS);
   localparam int unsigned MEM_AW      = ADDR_LEN - REGION_BITS - 2;
   localparam int unsigned OCC_W       = $clog2(RSP_DEPTH + 1);
   localparam int unsigned CNT_W       = OCC_W + 1;

   logic [REGION_BITS-1:0] region_c;
   logic                   bad_c, acc_c, pop_c, push_c, req_ready_c;
   logic [NUM_REGIONS-1:0] mem_en_c;
   logic [XLEN-1:0]        rd_word_c;
   logic [CNT_W-1:0]       committed_c;
   logic                   p_valid_q, p_err_q;
   logic [REGION_BITS-1:0] p_region_q;
   logic [OCC_W-1:0]       occ;
   rsp_t                   push_data_c, head;

   // Address decode.
   assign region_c = REGION_BITS'(region_of(32'(bus.req_addr), ADDR_LEN, REGION_BITS));
   assign bus.mem_addr = MEM_AW'(word_addr_of(32'(bus.req_addr), ADDR_LEN, REGION_BITS));
   assign bad_c = (bus.req_addr[1:0] != 2'b00) || !REGION_EN[region_c];

   // Reserve a buffer slot for every read in flight: memory data cannot be re-read.
   assign pop_c       = bus.rsp_valid && bus.rsp_ready;
   assign committed_c = CNT_W'(occ) + CNT_W'(p_valid_q) - CNT_W'(pop_c);
   assign req_ready_c = rstb && (bus.flush || (committed_c < CNT_W'(RSP_DEPTH)));
   assign bus.req_ready = req_ready_c;
   assign acc_c = bus.req_valid && req_ready_c;

   // One-hot read enable, suppressed for illegal fetches.
   always_comb begin
      mem_en_c = '0;
      for (int r = 0; r < int'(NUM_REGIONS); r++) begin
         if (acc_c && !bad_c && (region_c == REGION_BITS'(r))) mem_en_c[r] = 1'b1;
      end
   end
   assign bus.mem_en = mem_en_c;

   // Stage P: remember what was issued last cycle.
   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         p_valid_q  <= 1'b0;
         p_err_q    <= 1'b0;
         p_region_q <= '0;
      end else begin
         p_valid_q <= acc_c;
         if (acc_c) begin
            p_err_q    <= bad_c;
            p_region_q <= region_c;
         end
      end
   end

   // Select the returning read word of the region issued last cycle.
   always_comb begin
      rd_word_c = '0;
      for (int r = 0; r < int'(NUM_REGIONS); r++) begin
         if (p_region_q == REGION_BITS'(r)) rd_word_c = bus.mem_rdata[r*XLEN +: XLEN];
      end
   end

   // Capture into the buffer; a flush drops the read that is returning now.
   assign push_c           = p_valid_q && !bus.flush;
   assign push_data_c.err  = p_err_q;
   assign push_data_c.data = p_err_q ? ILLEGAL_INSTR : rd_word_c;

   i_fetch_rsp_fifo #(
      .DEPTH (RSP_DEPTH),
      .OCC_W (OCC_W)
   ) u_rsp_fifo (
      .clk         (clk),
      .rstb        (rstb),
      .push_i      (push_c),
      .push_data_i (push_data_c),
      .pop_i       (pop_c),
      .clear_i     (bus.flush),
      .occ_o       (occ),
      .head_o      (head)
   );

   assign bus.rsp_valid = (occ != '0);
   assign bus.rsp_data  = head.data;
   assign bus.rsp_err   = head.err;

endmodule

// File: tb/tb_i_fetch_mux.sv
// Bench for i_fetch_mux: queue-based response model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_i_fetch_mux;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned ALEN  = 14;
   localparam int unsigned NR    = 2;
   localparam int          DEPTH = 2;
   localparam int          WORDS = 2048;

   logic clk  = 1'b0;
   logic rstb = 1'b0;
   always #5 clk = ~clk;

   i_fetch_mux_if #(.XLEN(XLEN), .ADDR_LEN(ALEN), .NUM_REGIONS(NR)) bus ();
   i_fetch_mux_if #(.XLEN(XLEN), .ADDR_LEN(ALEN), .NUM_REGIONS(NR)) bus2 ();

   i_fetch_mux #(.XLEN(XLEN), .ADDR_LEN(ALEN), .NUM_REGIONS(NR),
                 .REGION_EN(2'b11), .RSP_DEPTH(DEPTH)) dut (
      .clk (clk), .rstb (rstb), .bus (bus.slave));

   // Second instance with only region 0 populated.
   i_fetch_mux #(.XLEN(XLEN), .ADDR_LEN(ALEN), .NUM_REGIONS(NR),
                 .REGION_EN(2'b01), .RSP_DEPTH(DEPTH)) dut_r0 (
      .clk (clk), .rstb (rstb), .bus (bus2.slave));

   assign bus2.flush     = bus.flush;
   assign bus2.req_valid = bus.req_valid;
   assign bus2.req_addr  = bus.req_addr;
   assign bus2.rsp_ready = 1'b1;
   assign bus2.mem_rdata = bus.mem_rdata;

   // Instruction memories: one-cycle read; garbage when not enabled.
   logic [31:0] mem_arr [NR][WORDS];
   always @(posedge clk) begin
      for (int r = 0; r < int'(NR); r++)
         bus.mem_rdata[r*32 +: 32] <= bus.mem_en[r] ? mem_arr[r][bus.mem_addr]
                                                    : (32'hBAD0_0000 | 32'(r));
   end

   int n_chk = 0, n_fail = 0;
   int cyc = 0, dut_pop_cnt = 0, dut_acc_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: every accepted, unflushed, undelivered fetch with the cycle it becomes visible.
   typedef struct {
      int          vis;
      logic        err;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   always @(negedge clk) begin : model
      logic m_valid, m_pop, m_ready, m_acc, m_bad;
      exp_t e;
      if (bus.rsp_valid && bus.rsp_ready) dut_pop_cnt++;
      if (bus.req_valid && bus.req_ready) dut_acc_cnt++;
      if (!rstb) begin
         exp_q.delete();
         chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
         chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
         chk("rst_mem_en", 32'(bus.mem_en), 32'd0);
      end else begin
         m_valid = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
         m_pop   = m_valid && bus.rsp_ready;
         m_ready = bus.flush || ((exp_q.size() - int'(m_pop)) < DEPTH);
         m_acc   = bus.req_valid && m_ready;
         m_bad   = (bus.req_addr[1:0] != 2'b00);
         chk("req_ready", 32'(bus.req_ready), 32'(m_ready));
         chk("rsp_valid", 32'(bus.rsp_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rsp_data", bus.rsp_data, exp_q[0].data);
            chk("rsp_err", 32'(bus.rsp_err), 32'(exp_q[0].err));
         end
         chk("mem_en", 32'(bus.mem_en),
             (m_acc && !m_bad) ? (32'd1 << bus.req_addr[13]) : 32'd0);
         if (bus.req_valid) chk("mem_addr", 32'(bus.mem_addr), 32'(bus.req_addr[12:2]));
         if (m_pop) void'(exp_q.pop_front());
         if (bus.flush) exp_q.delete();
         if (m_acc) begin
            e.vis  = cyc + 2;
            e.err  = m_bad;
            e.data = m_bad ? 32'd0 : mem_arr[int'(bus.req_addr[13])][int'(bus.req_addr[12:2])];
            exp_q.push_back(e);
         end
      end
      cyc++;
   end

   task automatic drv(input logic v, input logic [13:0] a, input logic f, input logic rr);
      bus.req_valid = v;
      bus.req_addr  = a;
      bus.flush     = f;
      bus.rsp_ready = rr;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int p0, a0;
      logic acc;
      logic [13:0] addr;
      for (int r = 0; r < int'(NR); r++)
         for (int w = 0; w < WORDS; w++)
            mem_arr[r][w] = (32'(r) << 28) | (32'(w) << 4) | 32'h5;
      mem_arr[0][4] = 32'h0050_0093;
      mem_arr[1][2] = 32'hFFF0_0113;
      drv(1'b0, 14'h0, 1'b0, 1'b1);
      repeat (2) step();
      rstb = 1'b1;
      step();

      // ROM fetch
      drv(1'b1, 14'h0010, 1'b0, 1'b1); #1;
      chk("rom_mem_en", 32'(bus.mem_en), 32'h1);
      chk("rom_mem_addr", 32'(bus.mem_addr), 32'h004);
      step(); drv(1'b0, 14'h0, 1'b0, 1'b1);
      chk("rom_n1_valid", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("rom_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rom_data", bus.rsp_data, 32'h0050_0093);
      chk("rom_err", 32'(bus.rsp_err), 32'd0);
      step();

      // RAM fetch
      drv(1'b1, 14'h2008, 1'b0, 1'b1); #1;
      chk("ram_mem_en", 32'(bus.mem_en), 32'h2);
      chk("ram_mem_addr", 32'(bus.mem_addr), 32'h002);
      step(); drv(1'b0, 14'h0, 1'b0, 1'b1);
      step();
      chk("ram_valid", 32'(bus.rsp_valid), 32'd1);
      chk("ram_data", bus.rsp_data, 32'hFFF0_0113);
      chk("ram_err", 32'(bus.rsp_err), 32'd0);
      step();

      // Streaming
      p0 = dut_pop_cnt;
      for (int i = 0; i < 8; i++) begin
         drv(1'b1, 14'(i * 4), 1'b0, 1'b1); #1;
         chk("stream_ready", 32'(bus.req_ready), 32'd1);
         step();
      end
      drv(1'b0, 14'h0, 1'b0, 1'b1);
      repeat (4) step();
      chk("stream_count", 32'(dut_pop_cnt - p0), 32'd8);

      // Backpressure: core holds its request until accepted
      a0 = dut_acc_cnt;
      addr = 14'h0040;
      for (int i = 0; i < 6; i++) begin
         drv(1'b1, addr, 1'b0, 1'b0); #1;
         acc = bus.req_ready;
         step();
         if (acc) addr = addr + 14'd4;
      end
      #1;
      chk("bp_accepted", 32'(dut_acc_cnt - a0), 32'd2);
      chk("bp_ready_low", 32'(bus.req_ready), 32'd0);
      chk("bp_head", bus.rsp_data, 32'h0000_0105);
      repeat (2) step();
      chk("bp_head_stable", bus.rsp_data, 32'h0000_0105);
      p0 = dut_pop_cnt;
      drv(1'b0, 14'h0, 1'b0, 1'b1);
      repeat (4) step();
      chk("bp_drained", 32'(dut_pop_cnt - p0), 32'd2);

      // Flush with the branch target accepted in the same cycle
      drv(1'b1, 14'h0000, 1'b0, 1'b0); step();
      drv(1'b1, 14'h0004, 1'b0, 1'b0); step();
      drv(1'b1, 14'h2000, 1'b1, 1'b0); #1;
      chk("flush_ready", 32'(bus.req_ready), 32'd1);
      step(); drv(1'b0, 14'h0, 1'b0, 1'b1);
      chk("flush_next_valid", 32'(bus.rsp_valid), 32'd0);
      step();
      chk("flush_tgt_valid", 32'(bus.rsp_valid), 32'd1);
      chk("flush_tgt_data", bus.rsp_data, 32'h1000_0005);
      step();
      chk("flush_no_stale", 32'(bus.rsp_valid), 32'd0);

      // Misaligned fetch
      drv(1'b1, 14'h0006, 1'b0, 1'b1); #1;
      chk("mis_mem_en", 32'(bus.mem_en), 32'd0);
      step(); drv(1'b0, 14'h0, 1'b0, 1'b1);
      step();
      chk("mis_valid", 32'(bus.rsp_valid), 32'd1);
      chk("mis_err", 32'(bus.rsp_err), 32'd1);
      chk("mis_data", bus.rsp_data, 32'd0);

      // Unpopulated region on the region-0-only instance
      repeat (3) step();
      drv(1'b1, 14'h2000, 1'b0, 1'b1); #1;
      chk("r0_mem_en", 32'(bus2.mem_en), 32'd0);
      step(); drv(1'b0, 14'h0, 1'b0, 1'b1);
      chk("r0_n1_valid", 32'(bus2.rsp_valid), 32'd0);
      step();
      chk("r0_valid", 32'(bus2.rsp_valid), 32'd1);
      chk("r0_err", 32'(bus2.rsp_err), 32'd1);
      chk("r0_data", bus2.rsp_data, 32'd0);
      step();

      // Async reset mid-stream
      for (int i = 0; i < 4; i++) begin
         drv(1'b1, 14'(14'h0100 + i * 4), 1'b0, 1'b1);
         step();
      end
      chk("pre_rst_valid", 32'(bus.rsp_valid), 32'd1);
      #2 rstb = 1'b0;
      #1;
      chk("rst_async_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_async_mem_en", 32'(bus.mem_en), 32'd0);
      drv(1'b0, 14'h0, 1'b0, 1'b1);
      @(posedge clk); #3 rstb = 1'b1;
      repeat (4) step();
      chk("post_rst_valid", 32'(bus.rsp_valid), 32'd0);
      chk("post_rst_ready", 32'(bus.req_ready), 32'd1);
      repeat (2) step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/i_fetch_mux.md
Name: i_fetch_mux

Overview:
Pipelined instruction-fetch router that takes fetch requests from the core. Decodes each address into one of NUM_REGIONS instruction memories (ROM, RAM, ...) and returns the read word through a valid/ready response channel.
- Instruction memories are synchronous, with a fixed one-cycle read latency.
- The block tracks in-flight reads and buffers responses against core backpressure.
- It supports a branch flush and flags illegal fetches.
- Sits between the core fetch stage and the instruction memories; replaces the purely combinational ROM/RAM instruction mux.

Parameters:
XLEN, 32, instruction/data word width
ADDR_LEN, 14, byte-address width of the fetch request
NUM_REGIONS, 2, number of instruction memories; power of two, >=2
REGION_BITS, $clog2(NUM_REGIONS), region index width; derived, not overridden
REGION_EN, {NUM_REGIONS{1'b1}}, bit r=1 means region r is populated
RSP_DEPTH, 2, response buffer depth, >=2

Ports:
clk  in  1  clock
rstb  in  1  reset, asynchronous, active-low
flush  in  1  discard all in-flight and buffered responses
req_valid  in  1  fetch request valid
req_ready  out  1  request accepted when req_valid && req_ready
req_addr  in  ADDR_LEN  fetch byte address
rsp_valid  out  1  response valid
rsp_ready  in  1  core accepts response
rsp_data  out  XLEN  fetched instruction word
rsp_err  out  1  illegal fetch (misaligned or unpopulated region)
mem_en  out  NUM_REGIONS  one-hot read enable per region
mem_addr  out  ADDR_LEN-REGION_BITS-2  word address, shared by all regions
mem_rdata  in  NUM_REGIONS*XLEN  read data; region r occupies [r*XLEN +: XLEN], valid the cycle after mem_en[r]

Behaviour:
- Reset (rstb low, async): pipeline valid p_valid=0, buffer empty, rsp_valid=0, rsp_data=0, rsp_err=0, mem_en=0. req_ready=1 once reset is released.
- Decode:
  - region = req_addr[ADDR_LEN-1 -: REGION_BITS].
  - mem_addr = req_addr[ADDR_LEN-REGION_BITS-1:2], combinational.
  - bad = (req_addr[1:0]!=0) || !REGION_EN[region].
- Accept: acc = req_valid && req_ready. mem_en[region] = acc && !bad, combinational, same cycle. No enable is issued for bad requests.
- Stage P (registered on acc): p_valid, p_region, p_err=bad. If acc=0, p_valid<=0.
- Stage P+1: if p_valid, push {data, err} into the response FIFO.
  - data = mem_rdata[p_region] when p_err=0, else ILLEGAL_INSTR (32'h0000_0000); err = p_err.
  - Push is same-cycle capture of mem_rdata; there is no second read.
- Latency: request accepted in cycle N; rsp_valid=1 in N+2 at the earliest (FIFO output is registered).
- Output: rsp_valid = FIFO non-empty; rsp_data/rsp_err = FIFO head. Pop when rsp_valid && rsp_ready. Outputs hold stable while rsp_valid && !rsp_ready.
- Flow control: req_ready = (occ + p_valid - pop) < RSP_DEPTH.
  - This guarantees no FIFO overflow: memory data cannot be re-read, so a slot is reserved before issue.
  - Sustains 1 fetch/cycle when rsp_ready stays high.
- Flush:
  - In a flush cycle: FIFO cleared, p_valid's pending push dropped, rsp_valid=0 the next cycle.
  - A request accepted in the same cycle as flush (the new branch target) is kept; req_ready evaluates as if the FIFO were empty.
  - The memory read for a dropped in-flight request still happens; its data is discarded.
- Simultaneous push and pop on a full FIFO: legal, occupancy unchanged.
- Reset mid-operation: all in-flight state is lost; no response is emitted for requests accepted before reset.
- No combinational path from mem_rdata to rsp_*.

Decomposition:
- Package i_fetch_pkg: ILLEGAL_INSTR constant; region_of() and word_addr_of() functions; rsp_t struct {logic err; logic [XLEN-1:0] data}.
- Sub-module i_fetch_rsp_fifo:
  - Parametrised synchronous FIFO of rsp_t, depth RSP_DEPTH.
  - Ports: push, pop, clear, occ output, head outputs.
  - Async active-low reset on clk/rstb.

Test Plan:
- ROM fetch: addr 0x0010, rom word 0x00500093 -> mem_en=2'b01, mem_addr=0x004 in cycle N; rsp_valid with rsp_data=0x00500093, rsp_err=0 in N+2.
- RAM fetch: addr 0x2008, ram word 0xFFF00113 -> mem_en=2'b10, mem_addr=0x002; rsp_data=0xFFF00113, rsp_err=0.
- Streaming: 8 back-to-back requests 0x0000..0x001C, rsp_ready=1 -> req_ready stays 1; 8 responses on consecutive cycles, in order.
- Backpressure: rsp_ready=0 while streaming -> at most 2 accepted, then req_ready=0. Head is held stable; on rsp_ready=1 all responses drain in order, none lost or duplicated.
- Flush: 2 requests in flight plus flush with new request 0x2000 in the same cycle -> old responses never appear; the next rsp_valid carries the word from 0x2000.
- Errors:
  - addr 0x0006 -> no mem_en; response rsp_err=1, rsp_data=0.
  - REGION_EN=2'b01 with addr 0x2000 -> rsp_err=1.
  - Async rstb pulse mid-stream -> rsp_valid=0 immediately, no stale response afterwards.
